frame_min_tracker: RTL

- Streaming downstream consumer of the registered pairwise-minimum stage; accepts one DATA_W-bit sample per handshake and reduces each frame of FRAME_LEN samples to its minimum value and the index of that minimum.
- Produces one result per frame on a valid/ready output port and holds it until it is consumed.
- Sits between the min-compare stage and the statistics/report logic.

---
 rtl/frame_min_tracker.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/frame_min_tracker.sv
// rtl/frame_min_tracker.sv - per-frame minimum/index reducer with valid/ready result hold
// Optional FRAME_MIN_TRACKER_MAX_EN adds the out_max frame maximum output.
module frame_min_tracker #(
  parameter int DATA_W    = 8,
  parameter int FRAME_LEN = 16,
  parameter int IDX_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_min,
  output logic [IDX_W-1:0]  out_idx,
`ifdef FRAME_MIN_TRACKER_MAX_EN
  output logic [DATA_W-1:0] out_max,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam bit               SINGLE = (FRAME_LEN == 1);
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(FRAME_LEN - 1);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   count_q, count_d;
  logic [DATA_W-1:0]  run_min_q, run_min_d;
  logic [IDX_W-1:0]   run_idx_q, run_idx_d;
  logic [DATA_W-1:0]  out_min_q, out_min_d;
  logic [IDX_W-1:0]   out_idx_q, out_idx_d;
  logic [DATA_W-1:0]  new_min;
  logic [IDX_W-1:0]   new_idx;
`ifdef FRAME_MIN_TRACKER_MAX_EN
  logic [DATA_W-1:0]  run_max_q, run_max_d;
  logic [DATA_W-1:0]  out_max_q, out_max_d;
  logic [DATA_W-1:0]  new_max;
`endif

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    run_min_d = run_min_q;
    run_idx_d = run_idx_q;
    out_min_d = out_min_q;
    out_idx_d = out_idx_q;
    // Strict compare keeps the earliest index on ties
    new_min   = (in_data < run_min_q) ? in_data : run_min_q;
    new_idx   = (in_data < run_min_q) ? count_q : run_idx_q;
`ifdef FRAME_MIN_TRACKER_MAX_EN
    run_max_d = run_max_q;
    out_max_d = out_max_q;
    new_max   = (in_data > run_max_q) ? in_data : run_max_q;
`endif
    case (state_q)
      IDLE: begin
        if (clear) begin
          count_d = '0;
        end else if (in_valid) begin
          run_min_d = in_data;
          run_idx_d = '0;
`ifdef FRAME_MIN_TRACKER_MAX_EN
          run_max_d = in_data;
`endif
          if (SINGLE) begin
            out_min_d = in_data;
            out_idx_d = '0;
`ifdef FRAME_MIN_TRACKER_MAX_EN
            out_max_d = in_data;
`endif
            count_d   = '0;
            state_d   = HOLD;
          end else begin
            count_d = IDX_W'(1);
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (clear) begin
          count_d = '0;
          state_d = IDLE;
        end else if (in_valid) begin
          if (count_q == LAST) begin
            out_min_d = new_min;
            out_idx_d = new_idx;
`ifdef FRAME_MIN_TRACKER_MAX_EN
            out_max_d = new_max;
`endif
            count_d   = '0;
            state_d   = HOLD;
          end else begin
            run_min_d = new_min;
            run_idx_d = new_idx;
`ifdef FRAME_MIN_TRACKER_MAX_EN
            run_max_d = new_max;
`endif
            count_d   = count_q + IDX_W'(1);
          end
        end
      end
      HOLD: begin
        // clear is ignored here so a finished result is never dropped
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      run_min_q <= '0;
      run_idx_q <= '0;
      out_min_q <= '0;
      out_idx_q <= '0;
`ifdef FRAME_MIN_TRACKER_MAX_EN
      run_max_q <= '0;
      out_max_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      run_min_q <= run_min_d;
      run_idx_q <= run_idx_d;
      out_min_q <= out_min_d;
      out_idx_q <= out_idx_d;
`ifdef FRAME_MIN_TRACKER_MAX_EN
      run_max_q <= run_max_d;
      out_max_q <= out_max_d;
`endif
    end
  end

  assign in_ready  = (state_q != HOLD);
  assign out_valid = (state_q == HOLD);
  assign busy      = (state_q == ACCUM);
  assign out_min   = out_min_q;
  assign out_idx   = out_idx_q;
`ifdef FRAME_MIN_TRACKER_MAX_EN
  assign out_max   = out_max_q;
`endif

endmodule
